// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a borrow flop,
// LSB first, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             diff;
    logic             borrow_next;
    logic             last_bit;
    logic             accept;

    always_comb begin
        x           = a_sr[0];
        y           = b_sr[0];
        diff        = x ^ y ^ borrow;
        borrow_next = (~x & y) | (~(x ^ y) & borrow);
        last_bit    = (cnt == CW'(WIDTH - 1));
        accept      = in_valid && (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // bo is a separate copy of the borrow so loading bin in IDLE leaves the
    // previous result untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bo     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    d      <= {diff, d[WIDTH-1:1]};
                    borrow <= borrow_next;
                    bo     <= borrow_next;
                    if (!last_bit) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
